unified_mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the pipeline's instruction-fetch requester (IF) and data-memory requester (DM, MEM stage).
- Fixed priority to DM, with a starvation limit that forces an IF grant.
- Registers each accepted transaction and holds it on the memory port until the memory returns ready.
- Returns read data or write acknowledge to the owner. The hazard logic stalls on a requester until its rvalid.

---
 rtl/unified_mem_arbiter_pkg.sv | 7 +
 rtl/unified_mem_arbiter_starve.sv | 21 ++
 rtl/unified_mem_arbiter.sv | 75 +++++++
 tb/tb_unified_mem_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared state encoding, owner IDs and default starvation limit
package unified_mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;
  localparam int MAX_WAIT_DEF = 3;
endpackage

// File: rtl/unified_mem_arbiter_starve.sv
// arb_starve_counter: counts DM wins over a pending IF and forces IF at the limit
module arb_starve_counter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic both_req,
  input  logic dm_win,
  input  logic if_win,
  output logic force_if
);
  localparam logic [3:0] LIM = 4'(MAX_WAIT);
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (if_win) cnt <= '0;
    else if (both_req && dm_win && cnt != LIM) cnt <= cnt + 4'd1;
  assign force_if = cnt == LIM;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between fetch and data requesters
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state, state_nx;
  logic force_if, both_req, dm_win, if_win, done, if_ok, win_own, kill_pend;
  arb_starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk(clk), .rst(rst), .both_req(both_req), .dm_win(dm_win), .if_win(if_win), .force_if(force_if)
  );
  always_comb begin
    both_req = state == IDLE && if_req && dm_req;
    dm_win   = state == IDLE && dm_req && !(if_req && force_if);
    if_win   = state == IDLE && if_req && !dm_win;
    win_own  = dm_win ? OWN_DM : OWN_IF;
    done     = state != IDLE && mem_ready;
    if_ok    = done && state == BUSY_I && !(kill_pend || if_kill);
    state_nx = dm_win ? BUSY_D : if_win ? BUSY_I : done ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      kill_pend <= 1'b0;
    end else begin
      state     <= state_nx;
      if_gnt    <= if_win;
      dm_gnt    <= dm_win;
      if_rvalid <= if_ok;
      dm_rvalid <= done && state == BUSY_D;
      kill_pend <= state == BUSY_I && !mem_ready && (kill_pend || if_kill);
      if (dm_win || if_win) begin
        mem_req   <= 1'b1;
        mem_we    <= win_own == OWN_DM && dm_we;
        mem_addr  <= win_own == OWN_DM ? dm_addr : if_addr;
        mem_wdata <= win_own == OWN_DM ? dm_wdata : '0;
      end else if (done) mem_req <= 1'b0;
      if (if_ok) if_rdata <= mem_rdata;
      if (done && state == BUSY_D && !mem_we) dm_rdata <= mem_rdata;
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: scoreboard bench for grants and responses of the memory arbiter
module tb_unified_mem_arbiter;
  localparam int IFG = 0, DMG = 1, IFR = 2, DMR = 3;
  typedef struct packed {logic [2:0] kind; logic [31:0] cyc; logic [31:0] data;} ev_t;
  logic clk = 1'b0, rst = 1'b0;
  logic if_req = 0, if_kill = 0, dm_req = 0, dm_we = 0, mem_ready = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, rd_val = 0;
  logic if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  int total = 0, bad = 0, cyc = 0, lat = 1, bc = 0, c;
  logic mem_en = 1'b1;
  ev_t exp_q[$];
  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(rd_val)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (mem_req && mem_en) begin
      bc++;
      mem_ready = bc == lat;
      if (mem_ready) bc = 0;
    end else begin
      mem_ready = 1'b0;
      bc = 0;
    end
  end
  always @(negedge clk) if (rst) begin
    for (int k = 0; k < 4; k++) begin
      logic v;
      logic [31:0] d;
      ev_t e;
      v = k == IFG ? if_gnt : k == DMG ? dm_gnt : k == IFR ? if_rvalid : dm_rvalid;
      d = k < 2 ? mem_addr : k == IFR ? if_rdata : dm_rdata;
      if (v) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event kind=%0d cyc=%0d data=%h (none expected)", k, cyc, d);
        end else begin
          e = exp_q.pop_front();
          if (32'(e.kind) != k || e.cyc != cyc || e.data !== d) begin
            bad++;
            $display("FAIL event got kind=%0d cyc=%0d data=%h want kind=%0d cyc=%0d data=%h",
                     k, cyc, d, e.kind, e.cyc, e.data);
          end
        end
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic exp_ev(input int k, input int cy, input logic [31:0] d);
    ev_t e;
    e.kind = 3'(k);
    e.cyc  = cy;
    e.data = d;
    exp_q.push_back(e);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    step(1);
    chk("reset_ctrl", {26'd0, mem_req, mem_we, if_gnt, dm_gnt, if_rvalid, dm_rvalid}, 0);
    chk("reset_rdata", if_rdata | dm_rdata, 0);
    rst = 1'b1;
    step(1);
    c = cyc;
    if_req = 1; if_addr = 32'h100; dm_req = 1; dm_we = 0; dm_addr = 32'h200; rd_val = 32'h55;
    exp_ev(DMG, c + 1, 32'h200); exp_ev(DMR, c + 2, 32'h55);
    exp_ev(IFG, c + 3, 32'h100); exp_ev(IFR, c + 4, 32'h55);
    step(1);
    dm_req = 0;
    chk("first_both_starve_cnt", 32'(dut.u_starve.cnt), 1);
    step(2);
    if_req = 0;
    step(2);
    c = cyc;
    if_req = 1; if_addr = 32'h10; rd_val = 32'h00500093;
    exp_ev(IFG, c + 1, 32'h10); exp_ev(IFR, c + 2, 32'h00500093);
    step(1);
    if_req = 0;
    @(negedge clk);
    chk("if_read_mem", {mem_addr[30:0], mem_we}, {31'h10, 1'b0});
    chk("if_read_req", 32'(mem_req), 1);
    step(2);
    c = cyc;
    dm_req = 1; dm_we = 0; dm_addr = 32'h80; rd_val = 32'hCAFEF00D;
    exp_ev(DMG, c + 1, 32'h80); exp_ev(DMR, c + 2, 32'hCAFEF00D);
    step(1);
    dm_req = 0;
    step(2);
    c = cyc;
    dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF; lat = 3; rd_val = 32'h11111111;
    exp_ev(DMG, c + 1, 32'h40); exp_ev(DMR, c + 4, 32'hCAFEF00D);
    step(1);
    dm_req = 0; dm_we = 0; dm_wdata = 0; dm_addr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wr_hold_ctrl", {30'd0, mem_req, mem_we}, 3);
      chk("wr_hold_addr", mem_addr, 32'h40);
      chk("wr_hold_wdata", mem_wdata, 32'hDEADBEEF);
    end
    step(2);
    lat = 1;
    c = cyc;
    if_req = 1; if_addr = 32'h400; dm_req = 1; dm_we = 0; dm_addr = 32'h300; rd_val = 32'h77;
    for (int j = 0; j < 8; j++) begin
      exp_ev(j % 4 == 3 ? IFG : DMG, c + 1 + 2 * j, j % 4 == 3 ? 32'h400 : 32'h300);
      exp_ev(j % 4 == 3 ? IFR : DMR, c + 2 + 2 * j, 32'h77);
    end
    step(16);
    if_req = 0; dm_req = 0;
    step(2);
    c = cyc;
    if_req = 1; if_addr = 32'h20; rd_val = 32'h1234; lat = 2;
    exp_ev(IFG, c + 1, 32'h20);
    exp_ev(DMG, c + 4, 32'h50); exp_ev(DMR, c + 5, 32'h1234);
    step(1);
    if_req = 0; if_kill = 1; dm_req = 1; dm_addr = 32'h50;
    step(1);
    if_kill = 0; lat = 1;
    step(1);
    chk("kill_no_rvalid", 32'(if_rvalid), 0);
    chk("kill_rdata_kept", if_rdata, 32'h77);
    step(1);
    dm_req = 0;
    step(2);
    c = cyc;
    if_req = 1; if_addr = 32'h24; rd_val = 32'h9999;
    exp_ev(IFG, c + 1, 32'h24);
    step(1);
    if_req = 0; if_kill = 1;
    step(1);
    if_kill = 0;
    chk("kill_at_ready_rvalid", 32'(if_rvalid), 0);
    chk("kill_at_ready_rdata", if_rdata, 32'h77);
    step(2);
    c = cyc;
    if_req = 1; if_kill = 1; if_addr = 32'h28; rd_val = 32'hABCD;
    exp_ev(IFG, c + 1, 32'h28); exp_ev(IFR, c + 2, 32'hABCD);
    step(1);
    if_req = 0; if_kill = 0;
    step(3);
    mem_en = 0;
    c = cyc;
    dm_req = 1; dm_we = 0; dm_addr = 32'h60;
    exp_ev(DMG, c + 1, 32'h60);
    step(1);
    dm_req = 0;
    step(1);
    chk("pre_reset_busy", 32'(mem_req), 1);
    rst = 1'b0;
    #1;
    chk("async_reset_ctrl", {26'd0, mem_req, mem_we, if_gnt, dm_gnt, if_rvalid, dm_rvalid}, 0);
    chk("async_reset_rdata", if_rdata | dm_rdata, 0);
    chk("async_reset_addr", mem_addr, 0);
    step(1);
    rst = 1'b1; mem_en = 1;
    step(1);
    chk("post_reset_state", 32'(dut.state), 0);
    step(5);
    chk("post_reset_idle", 32'(mem_req), 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
